// File: rtl/ss_pkg.sv
// Shared types and constants for the spread-spectrum carrier address generator.
package ss_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ss_state_e;

  localparam int unsigned PN_WIDTH  = 7;
  localparam int unsigned PN_TAP_HI = 6;
  localparam int unsigned PN_TAP_LO = 5;
  localparam int unsigned ADDR_W    = 3;

  localparam logic [PN_WIDTH-1:0] PN_SEED_DEFAULT = 7'b0000001;

  // x^7 + x^6 + 1, shifting toward the MSB; the MSB is the output chip
  function automatic logic [PN_WIDTH-1:0] pn_next(input logic [PN_WIDTH-1:0] s);
    return {s[PN_WIDTH-2:0], s[PN_TAP_HI] ^ s[PN_TAP_LO]};
  endfunction

endpackage

// File: rtl/pn_lfsr.sv
// 7-bit PN sequence generator; load has priority over step.
module pn_lfsr
  import ss_pkg::*;
#(
  parameter logic [PN_WIDTH-1:0] RST_SEED = PN_SEED_DEFAULT
) (
  input  logic                clk_s,
  input  logic                rst,
  input  logic                load,
  input  logic                step,
  input  logic [PN_WIDTH-1:0] seed,
  output logic                chip
);

  logic [PN_WIDTH-1:0] r_lfsr;

  always_ff @(posedge clk_s or posedge rst) begin
    if (rst)       r_lfsr <= RST_SEED;
    else if (load) r_lfsr <= seed;
    else if (step) r_lfsr <= pn_next(r_lfsr);
  end

  assign chip = r_lfsr[PN_WIDTH-1];

endmodule

// File: rtl/ss_addr_gen.sv
// BPSK spread-spectrum carrier-ROM address generator: one data bit is spread
// over CHIPS_PER_BIT PN chips of SAMPLES_PER_CHIP carrier samples each.
module ss_addr_gen
  import ss_pkg::*;
#(
  parameter int unsigned          SAMPLES_PER_CHIP = 8,
  parameter int unsigned          CHIPS_PER_BIT    = 127,
  parameter logic [PN_WIDTH-1:0]  PN_SEED          = PN_SEED_DEFAULT
) (
  input  logic              clk_s,
  input  logic              rst,
  input  logic              en,
  input  logic              data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic [ADDR_W-1:0] add,
  output logic              chip_out,
  output logic              bit_strobe,
  output logic              underrun
);

  localparam int unsigned SW = (SAMPLES_PER_CHIP > 1) ? $clog2(SAMPLES_PER_CHIP) : 1;
  localparam int unsigned CW = (CHIPS_PER_BIT > 1) ? $clog2(CHIPS_PER_BIT) : 1;
  localparam logic [SW-1:0] S_LAST = SW'(SAMPLES_PER_CHIP - 1);
  localparam logic [CW-1:0] C_LAST = CW'(CHIPS_PER_BIT - 1);

  ss_state_e         r_state, w_state_nxt;
  logic              r_bit, w_bit_nxt;
  logic [ADDR_W-1:0] r_phase, w_phase_nxt;
  logic [SW-1:0]     r_sample, w_sample_nxt;
  logic [CW-1:0]     r_chip, w_chip_nxt;
  logic              w_load, w_step, w_pn_chip;
  logic              w_run, w_bnd, w_xfer;

  pn_lfsr #(.RST_SEED(PN_SEED)) u_pn (
    .clk_s (clk_s),
    .rst   (rst),
    .load  (w_load),
    .step  (w_step),
    .seed  (PN_SEED),
    .chip  (w_pn_chip)
  );

  assign w_run      = (r_state == RUN);
  assign w_bnd      = w_run && (r_sample == S_LAST) && (r_chip == C_LAST);
  assign data_ready = !rst && en && (!w_run || w_bnd);
  assign w_xfer     = data_valid && data_ready;
  assign bit_strobe = w_xfer;
  assign underrun   = en && w_bnd && !data_valid;

  always_comb begin
    w_state_nxt  = r_state;
    w_bit_nxt    = r_bit;
    w_phase_nxt  = r_phase;
    w_sample_nxt = r_sample;
    w_chip_nxt   = r_chip;
    w_load       = 1'b0;
    w_step       = 1'b0;
    if (en) begin
      if (w_xfer) begin
        w_state_nxt  = RUN;
        w_bit_nxt    = data_in;
        w_phase_nxt  = '0;
        w_sample_nxt = '0;
        w_chip_nxt   = '0;
        w_load       = 1'b1;
      end else if (w_run) begin
        if (w_bnd) begin
          w_state_nxt  = IDLE;
          w_phase_nxt  = '0;
          w_sample_nxt = '0;
          w_chip_nxt   = '0;
          w_load       = 1'b1;
        end else begin
          w_phase_nxt = r_phase + ADDR_W'(1);
          if (r_sample == S_LAST) begin
            w_sample_nxt = '0;
            w_chip_nxt   = r_chip + CW'(1);
            w_step       = 1'b1;
          end else begin
            w_sample_nxt = r_sample + SW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk_s or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_bit    <= 1'b0;
      r_phase  <= '0;
      r_sample <= '0;
      r_chip   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_bit    <= w_bit_nxt;
      r_phase  <= w_phase_nxt;
      r_sample <= w_sample_nxt;
      r_chip   <= w_chip_nxt;
    end
  end

  // Adding 4 mod 8 only flips the MSB, so add is a gate-level decode of
  // registered phase, bit and chip; the chip register lives inside pn_lfsr.
  assign chip_out = w_run && w_pn_chip;
  assign add      = w_run ? {r_phase[ADDR_W-1] ^ r_bit ^ w_pn_chip, r_phase[ADDR_W-2:0]} : '0;

endmodule

// File: doc/ss_addr_gen.md
SS_ADDR_GEN -- requirements
Module: ss_addr_gen

Interface
REQ-001 SHALL have parameter SAMPLES_PER_CHIP, default 8; meaning: clocks (ROM samples) per PN chip, range 1..256.
REQ-002 SHALL have parameter CHIPS_PER_BIT, default 127; meaning: PN chips per data bit, range 1..1023.
REQ-003 SHALL have parameter PN_SEED, default 7'b0000001; meaning: LFSR load value, nonzero.
REQ-004 SHALL have port clk_s, input, 1; meaning: sole clock, all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1; meaning: asynchronous, active-high reset.
REQ-006 SHALL have port en, input, 1; meaning: advance enable; low freezes all state.
REQ-007 SHALL have port data_in, input, 1; meaning: payload bit.
REQ-008 SHALL have port data_valid, input, 1; meaning: data_in is valid.
REQ-009 SHALL have port data_ready, output, 1; meaning: block accepts data_in this cycle.
REQ-010 SHALL have port add, output, 3; meaning: carrier-ROM address to the downstream 8x8 sample ROM.
REQ-011 SHALL have port chip_out, output, 1; meaning: current PN chip, for monitoring.
REQ-012 SHALL have port bit_strobe, output, 1; meaning: one-cycle pulse when a bit is accepted.
REQ-013 SHALL have port underrun, output, 1; meaning: one-cycle pulse when no bit is available at a bit boundary.

Function
REQ-014 SHALL implement states IDLE and RUN.
REQ-015 In IDLE, data_ready SHALL equal en.
REQ-016 In RUN, data_ready SHALL equal en only on the last sample of the last chip of the current bit, and SHALL be 0 otherwise.
REQ-017 Transfer occurs when data_valid & data_ready; on that edge: capture data_in, reload LFSR to PN_SEED, clear sample and chip counters, enter or stay in RUN, pulse bit_strobe.
REQ-018 In RUN with en=1, the 3-bit phase counter SHALL increment every cycle, wrapping 7->0; it SHALL restart at 0 on each transfer.
REQ-019 The sample counter SHALL count 0..SAMPLES_PER_CHIP-1; at terminal count it SHALL wrap to 0, advance the LFSR one step and increment the chip counter.
REQ-020 The chip counter SHALL count 0..CHIPS_PER_BIT-1; terminal sample of the terminal chip is the bit boundary.
REQ-021 The LFSR SHALL be 7 bits, polynomial x^7+x^6+1: next = {lfsr[5:0], lfsr[6]^lfsr[5]}; chip_out = lfsr[6].
REQ-022 add SHALL be registered and equal (phase + 4*(bit ^ chip_out)) mod 8, i.e. a 180-degree BPSK offset when the spread chip is 1.
REQ-023 Latency: add for sample 0 of chip 0 SHALL be visible in the cycle after the transfer edge.
REQ-024 At a bit boundary with en=1 and no transfer, the block SHALL pulse underrun, return to IDLE, and drive add=0.
REQ-025 In IDLE, add SHALL be 0, chip_out SHALL be 0, and no counter SHALL advance.
REQ-026 en=0 SHALL hold every register, including add; bit_strobe and underrun SHALL be 0.
REQ-027 A transfer at the bit boundary SHALL start the next bit seamlessly, with no gap cycle.

Reset
REQ-028 rst=1 SHALL asynchronously force: state=IDLE, add=0, chip_out=0, data_ready=0, bit_strobe=0, underrun=0, LFSR=PN_SEED, all counters 0, stored bit 0.
REQ-029 Reset asserted mid-bit SHALL abandon the bit; after release, operation SHALL resume only via a new transfer.
REQ-030 Outputs SHALL be valid from the first edge after rst deasserts.

Structure
REQ-031 Package ss_pkg SHALL hold: the state enum (IDLE, RUN), PN_WIDTH=7, the tap positions, the default PN_SEED, and the ROM address width (3).
REQ-032 The LFSR SHALL be a sub-module pn_lfsr with ports clk_s, rst, load, step, seed, and chip.

Verification
REQ-033 Scenario: defaults; send bit 0 -> add = 0,1,...,7 repeating, chip_out=0 for chips 0-5 and 1 for chip 6; add for chip 6 = 4,5,6,7,0,1,2,3.
REQ-034 Scenario: send bit 1 -> chip 0 add = 4,5,6,7,0,1,2,3; bit_strobe high exactly one cycle at the transfer.
REQ-035 Scenario: back-to-back bits with data_valid held high -> data_ready pulses at cycle 127*8-1 of each bit, no gap, and the LFSR is reloaded to 0000001.
REQ-036 Scenario: data_valid low at the bit boundary -> underrun=1 for one cycle, state returns to IDLE, and add=0 on the next cycle.
REQ-037 Scenario: en low for 5 cycles mid-chip -> add, counters and LFSR frozen; sequence continues unchanged afterwards.
REQ-038 Scenario: rst pulsed mid-chip (not clock-aligned) -> add=0 immediately, data_ready=0; after release, data_ready=1 while en=1.
